// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM state codes,
// datapath widths and the word-alignment helper used for redirect targets.
package fetch_pkg;

    localparam int INST_W = 32;
    localparam int CNT_W  = 8;
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef logic [1:0] state_t;

    localparam state_t BOOT  = 2'd0;
    localparam state_t FETCH = 2'd1;
    localparam state_t ISSUE = 2'd2;
    localparam state_t ERR   = 2'd3;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Clearable up-counter with a terminal-count flag; shared between the boot
// delay and the fetch timeout since the two are never active together.
module fetch_timeout_ctr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign tc = (count_reg == limit);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch control: owns the PC, runs the imem req/ack handshake and
// hands each fetched word to decode over a valid/ready interface.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BOOT_CYCLES = 1,
    parameter int          TIMEOUT     = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [31:0]       pc_out,
    input  logic              inst_ready,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_target,
    output logic              fetch_err
);

    localparam logic [CNT_W-1:0] BOOT_LIM = CNT_W'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic [31:0]       pc_reg, pc_next;
    logic [31:0]       pc_tgt_reg, pc_tgt_next;
    logic              pend_redir_reg, pend_redir_next;
    logic              imem_req_reg, imem_req_next;
    logic              inst_valid_reg, inst_valid_next;
    logic [INST_W-1:0] inst_reg, inst_next;
    logic [31:0]       pc_out_reg, pc_out_next;
    logic              fetch_err_reg, fetch_err_next;

    logic              ctr_clear, ctr_inc, ctr_tc;
    logic [CNT_W-1:0]  ctr_limit;
    logic              ack_taken;
    logic [31:0]       redir_pc;

    fetch_timeout_ctr #(.W(CNT_W)) u_ctr (
        .clk   (clk),
        .srst  (reset),
        .clear (ctr_clear),
        .inc   (ctr_inc),
        .limit (ctr_limit),
        .tc    (ctr_tc)
    );

    // An ack only counts while a request is actually on the bus.
    assign ack_taken = imem_req_reg && imem_ack;
    assign redir_pc  = align_word(redirect_target);
    assign ctr_limit = (state_reg == BOOT) ? BOOT_LIM : TO_LIM;

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        pc_tgt_next     = pc_tgt_reg;
        pend_redir_next = pend_redir_reg;
        imem_req_next   = imem_req_reg;
        inst_valid_next = inst_valid_reg;
        inst_next       = inst_reg;
        pc_out_next     = pc_out_reg;
        fetch_err_next  = fetch_err_reg;
        ctr_clear       = 1'b0;
        ctr_inc         = 1'b0;

        case (state_reg)
            BOOT: begin
                ctr_inc = 1'b1;
                if (ctr_tc) begin
                    ctr_clear     = 1'b1;
                    state_next    = FETCH;
                    imem_req_next = 1'b1;
                end
            end
            FETCH: begin
                if (ack_taken) begin
                    ctr_clear     = 1'b1;
                    imem_req_next = 1'b0;
                    if (redirect_valid || pend_redir_reg) begin
                        // Stale data from the old path; refetch from the target.
                        pc_next         = redirect_valid ? redir_pc : pc_tgt_reg;
                        pend_redir_next = 1'b0;
                    end else begin
                        inst_next       = imem_rdata;
                        pc_out_next     = pc_reg;
                        inst_valid_next = 1'b1;
                        state_next      = ISSUE;
                    end
                end else begin
                    if (redirect_valid) begin
                        pend_redir_next = 1'b1;
                        pc_tgt_next     = redir_pc;
                    end
                    if (!imem_req_reg) begin
                        imem_req_next = 1'b1;
                    end else if (ctr_tc) begin
                        imem_req_next  = 1'b0;
                        fetch_err_next = 1'b1;
                        state_next     = ERR;
                    end else begin
                        ctr_inc = 1'b1;
                    end
                end
            end
            ISSUE: begin
                ctr_clear = 1'b1;
                if (inst_ready && !stall) begin
                    pc_next         = redirect_valid ? redir_pc : pc_reg + PC_STEP;
                    inst_valid_next = 1'b0;
                    imem_req_next   = 1'b1;
                    state_next      = FETCH;
                end
            end
            default: begin
                imem_req_next   = 1'b0;
                inst_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= BOOT;
            pc_reg         <= RESET_PC;
            pc_tgt_reg     <= RESET_PC;
            pend_redir_reg <= 1'b0;
            imem_req_reg   <= 1'b0;
            inst_valid_reg <= 1'b0;
            inst_reg       <= '0;
            pc_out_reg     <= RESET_PC;
            fetch_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            pc_tgt_reg     <= pc_tgt_next;
            pend_redir_reg <= pend_redir_next;
            imem_req_reg   <= imem_req_next;
            inst_valid_reg <= inst_valid_next;
            inst_reg       <= inst_next;
            pc_out_reg     <= pc_out_next;
            fetch_err_reg  <= fetch_err_next;
        end
    end

    assign imem_req   = imem_req_reg;
    assign imem_addr  = pc_reg;
    assign inst_valid = inst_valid_reg;
    assign inst       = inst_reg;
    assign pc_out     = pc_out_reg;
    assign fetch_err  = fetch_err_reg;

endmodule
